dot_product_sequencer: RTL and testbench
========================================

Name: dot_product_sequencer

Overview:
- Sequences one MultiplyAccumulator instance to compute dot products of FP32 vectors held in two synchronous-read operand memories (A and B).
- Per job: clears the MAC, streams Length operand pairs with configurable base addresses and strides, captures the MAC result, then signals Done.
- Sits between the layer control logic (job issue) and the exact-accumulation datapath.

Parameters:
ADDR_WIDTH, 10, width of operand memory addresses, Length and strides; all address arithmetic is modulo 2^ADDR_WIDTH.
DATA_WIDTH, 32, operand/result width (FP32); fixed at 32 to match the MAC.

Ports:
Clk  in  1  clock, all logic on posedge.
Rst  in  1  synchronous active-high reset.
Start  in  1  job request; sampled only in IDLE.
Abort  in  1  synchronous job cancel; honoured in any state except IDLE.
Length  in  ADDR_WIDTH  number of element pairs; latched on accepted Start.
BaseA, BaseB  in  ADDR_WIDTH each  first element address; latched on Start.
StrideA, StrideB  in  ADDR_WIDTH each  address increment per element; latched on Start.
RdEn  out  1  read strobe to both memories.
AddrA, AddrB  out  ADDR_WIDTH each  read addresses.
DataA, DataB  in  32 each  read data, valid the cycle after RdEn.
MacEnable  out  1  drives MAC Enable.
MacIn1, MacIn2  out  32 each  drive MAC In1/In2.
MacOut  in  32  MAC Out (combinational from MAC accumulator).
Busy  out  1  high in every state except IDLE.
Done  out  1  one-cycle completion pulse.
Result  out  32  captured dot product; held until next Done.

Behaviour:
- Reset: state IDLE; RdEn, MacEnable, Busy, Done = 0; MacIn1/2 = 0; Result = 0; addresses and counters = 0. Rst mid-job is identical: MacEnable low at the next edge clears the MAC.
- MAC contract: an edge with MacEnable=1 accumulates MacIn1*MacIn2. An edge with MacEnable=0 clears the MAC. MacOut is valid only while MacEnable=1.
- States: IDLE, FETCH, ACCUM, CAPTURE, DONE.
- IDLE: MacEnable=0 (MAC held clear). If Start=1, latch Length, bases and strides.
  - Length=0: go to DONE.
  - Otherwise: go to FETCH.
- FETCH (1 cycle): RdEn=1, AddrA=BaseA, AddrB=BaseB. issue_cnt=1, acc_cnt=0. MacEnable=0. Go to ACCUM.
- ACCUM (exactly Length cycles): MacEnable=1, MacIn1=DataA, MacIn2=DataB. acc_cnt increments each cycle.
  - While issue_cnt<Length: RdEn=1, addresses advance by StrideA/StrideB (wrap-around allowed), issue_cnt increments. Otherwise RdEn=0.
  - When acc_cnt reaches Length-1, go to CAPTURE.
- CAPTURE (1 cycle): MacEnable=1, MacIn1=MacIn2=0 (adds zero, sign unaffected). Result <= MacOut at the edge. Go to DONE.
- DONE (1 cycle): Done=1, MacEnable=0 (clears MAC), Busy=1. For Length=0, Result <= 0. Go to IDLE.
- Start outside IDLE is ignored, not queued. Start in the IDLE cycle after DONE is accepted; the MAC has then seen at least one clearing cycle (DONE plus IDLE).
- Latency: Start accepted at cycle 0 → Done at cycle Length+3 (Length≥1); cycle 1 for Length=0. Throughput: one job per Length+4 cycles.
- MacIn1/2 = 0 in every state other than ACCUM.
- Abort in FETCH/ACCUM/CAPTURE/DONE: go to IDLE next edge, no Done, Result unchanged, MacEnable=0 from that edge. Abort and Start together in IDLE: Start wins.
- Result is updated only in CAPTURE or in a Length=0 DONE.

Test Plan:
- Reset, then idle 5 cycles → Busy=0, Done=0, MacEnable=0, Result=0x00000000.
- A=[0x3F800000,0x40000000,0x40400000] (1,2,3), B=[1.0,1.0,1.0], Length=3, strides 1 → Done at cycle 6, Result=0x40C00000 (6.0), RdEn high cycles 1..3.
- A=[1.0,-3.0](0x3F800000,0xC0400000), B=[2.0,1.0] → Result=0xBF800000 (-1.0); sign flip through zero handled.
- StrideB=4, BaseB=2^ADDR_WIDTH-2, Length=2 → AddrB sequence 1022, 2 (wrap); result matches the model.
- Length=0 → Done at cycle 1, Result=0; back-to-back Start the cycle after Done → second job correct, no residue from the first.
- Abort during ACCUM of a Length=8 job → IDLE next cycle, no Done, Result keeps previous value; next job result correct.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// Drives one FP32 multiply-accumulator through a dot product of two strided vectors
// held in synchronous-read memories, then captures the sum and pulses Done.
module dot_product_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [ADDR_WIDTH-1:0] Length,
  input  logic [ADDR_WIDTH-1:0] BaseA,
  input  logic [ADDR_WIDTH-1:0] BaseB,
  input  logic [ADDR_WIDTH-1:0] StrideA,
  input  logic [ADDR_WIDTH-1:0] StrideB,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] AddrA,
  output logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataA,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  MacEnable,
  output logic [DATA_WIDTH-1:0] MacIn1,
  output logic [DATA_WIDTH-1:0] MacIn2,
  input  logic [DATA_WIDTH-1:0] MacOut,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACCUM,
    CAPTURE,
    DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_strideA;
  logic [ADDR_WIDTH-1:0] r_strideB;
  logic [ADDR_WIDTH-1:0] r_addrA;
  logic [ADDR_WIDTH-1:0] r_addrB;
  logic [ADDR_WIDTH-1:0] r_issueCnt;
  logic [ADDR_WIDTH-1:0] r_accCnt;
  logic                  r_zeroLen;
  logic                  r_rdEn;
  logic                  r_macEnable;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  w_inAccum;

  // Read data lands in the cycle after the strobe, so the MAC operands are a
  // combinational pass-through of the memory outputs while accumulating.
  assign w_inAccum = (r_state == ACCUM);
  assign MacIn1    = w_inAccum ? DataA : '0;
  assign MacIn2    = w_inAccum ? DataB : '0;

  assign RdEn      = r_rdEn;
  assign AddrA     = r_addrA;
  assign AddrB     = r_addrB;
  assign MacEnable = r_macEnable;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Result    = r_result;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_strideA   <= '0;
      r_strideB   <= '0;
      r_addrA     <= '0;
      r_addrB     <= '0;
      r_issueCnt  <= '0;
      r_accCnt    <= '0;
      r_zeroLen   <= 1'b0;
      r_rdEn      <= 1'b0;
      r_macEnable <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else if (r_state == IDLE) begin
      r_rdEn      <= 1'b0;
      r_macEnable <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      if (Start) begin
        r_len     <= Length;
        r_strideA <= StrideA;
        r_strideB <= StrideB;
        r_busy    <= 1'b1;
        if (Length == '0) begin
          r_state   <= DONE;
          r_done    <= 1'b1;
          r_zeroLen <= 1'b1;
        end else begin
          r_state    <= FETCH;
          r_rdEn     <= 1'b1;
          r_addrA    <= BaseA;
          r_addrB    <= BaseB;
          r_issueCnt <= ADDR_WIDTH'(1);
          r_accCnt   <= '0;
          r_zeroLen  <= 1'b0;
        end
      end
    end else if (Abort) begin
      // Dropping MacEnable here also clears the MAC on the following edge.
      r_state     <= IDLE;
      r_rdEn      <= 1'b0;
      r_macEnable <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        FETCH, ACCUM: begin
          // r_issueCnt counts reads already issued, including the current one.
          if (r_issueCnt < r_len) begin
            r_rdEn     <= 1'b1;
            r_addrA    <= r_addrA + r_strideA;
            r_addrB    <= r_addrB + r_strideB;
            r_issueCnt <= r_issueCnt + ADDR_WIDTH'(1);
          end else begin
            r_rdEn <= 1'b0;
          end
          r_macEnable <= 1'b1;
          if (r_state == FETCH) begin
            r_state <= ACCUM;
          end else begin
            r_accCnt <= r_accCnt + ADDR_WIDTH'(1);
            if (r_accCnt == r_len - ADDR_WIDTH'(1)) begin
              r_state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          r_result    <= MacOut;
          r_macEnable <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (r_zeroLen) begin
            r_result <= '0;
          end
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: behavioural operand memories and an
// exact real-valued MAC surround the DUT; expected sums are hand-computed FP32 constants.
module tb_dot_product_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic          Abort;
  logic [AW-1:0] Length;
  logic [AW-1:0] BaseA;
  logic [AW-1:0] BaseB;
  logic [AW-1:0] StrideA;
  logic [AW-1:0] StrideB;
  logic          RdEn;
  logic [AW-1:0] AddrA;
  logic [AW-1:0] AddrB;
  logic [DW-1:0] DataA;
  logic [DW-1:0] DataB;
  logic          MacEnable;
  logic [DW-1:0] MacIn1;
  logic [DW-1:0] MacIn2;
  logic [DW-1:0] MacOut;
  logic          Busy;
  logic          Done;
  logic [DW-1:0] Result;

  logic [DW-1:0] memA [0:1023];
  logic [DW-1:0] memB [0:1023];
  real           macAcc = 0.0;

  int checkCount = 0;
  int errorCount = 0;

  dot_product_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Length(Length),
    .BaseA(BaseA), .BaseB(BaseB), .StrideA(StrideA), .StrideB(StrideB),
    .RdEn(RdEn), .AddrA(AddrA), .AddrB(AddrB), .DataA(DataA), .DataB(DataB),
    .MacEnable(MacEnable), .MacIn1(MacIn1), .MacIn2(MacIn2), .MacOut(MacOut),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 Clk = ~Clk;

  function automatic real fp32ToReal(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] realToFp32(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Synchronous-read operand memories and an exact MAC that clears when disabled.
  always @(posedge Clk) begin
    if (RdEn) begin
      DataA <= memA[AddrA];
      DataB <= memB[AddrB];
    end
    if (MacEnable) macAcc <= macAcc + fp32ToReal(MacIn1) * fp32ToReal(MacIn2);
    else macAcc <= 0.0;
  end

  always_comb MacOut = realToFp32(macAcc);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic applyStimulus(input string name, input logic [AW-1:0] len,
                               input logic [AW-1:0] bA, input logic [AW-1:0] bB,
                               input logic [AW-1:0] sA, input logic [AW-1:0] sB,
                               input logic [31:0] expResult, input int expDone);
    int            doneCyc;
    int            rdCount;
    int            rdCyc [64];
    logic [AW-1:0] rdA [64];
    logic [AW-1:0] rdB [64];
    logic [AW-1:0] expA;
    logic [AW-1:0] expB;
    logic          macEnAtDone;
    logic          busyAtDone;
    doneCyc = -1;
    rdCount = 0;
    macEnAtDone = 1'b1;
    busyAtDone = 1'b0;
    Start = 1'b1; Length = len; BaseA = bA; BaseB = bB; StrideA = sA; StrideB = sB;
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      @(negedge Clk);
      if (RdEn && rdCount < 64) begin
        rdCyc[rdCount] = c;
        rdA[rdCount] = AddrA;
        rdB[rdCount] = AddrB;
        rdCount++;
      end
      if (Done) begin
        doneCyc = c;
        macEnAtDone = MacEnable;
        busyAtDone = Busy;
        break;
      end
    end
    checkOutput({name, " doneCycle"}, 32'(doneCyc), 32'(expDone));
    checkOutput({name, " macEnAtDone"}, 32'(macEnAtDone), 32'd0);
    checkOutput({name, " busyAtDone"}, 32'(busyAtDone), 32'd1);
    checkOutput({name, " readCount"}, 32'(rdCount), 32'(len));
    for (int k = 0; k < rdCount && k < int'(len); k++) begin
      expA = bA + AW'(k) * sA;
      expB = bB + AW'(k) * sB;
      checkOutput($sformatf("%s rdCycle%0d", name, k), 32'(rdCyc[k]), 32'(k + 1));
      checkOutput($sformatf("%s addrA%0d", name, k), 32'(rdA[k]), 32'(expA));
      checkOutput($sformatf("%s addrB%0d", name, k), 32'(rdB[k]), 32'(expB));
    end
    @(posedge Clk); #1;
    checkOutput({name, " result"}, Result, expResult);
    checkOutput({name, " busyAfter"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int doneSeen;
    for (int i = 0; i < 1024; i++) begin
      memA[i] = 32'h0;
      memB[i] = 32'h0;
    end
    memA[0] = 32'h3F800000; memA[1] = 32'h40000000; memA[2] = 32'h40400000;
    memB[0] = 32'h3F800000; memB[1] = 32'h3F800000; memB[2] = 32'h3F800000;
    memA[10] = 32'h3F800000; memA[11] = 32'hC0400000;
    memB[10] = 32'h40000000; memB[11] = 32'h3F800000;
    memA[20] = 32'h40000000; memA[23] = 32'h3F000000;
    memB[1022] = 32'h3FC00000;
    for (int i = 0; i < 8; i++) begin
      memA[100 + i] = 32'h3F800000;
      memB[200 + i] = 32'h3F800000;
    end

    Rst = 1'b1; Start = 1'b0; Abort = 1'b0;
    Length = '0; BaseA = '0; BaseB = '0; StrideA = '0; StrideB = '0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset busy", 32'(Busy), 32'd0);
    checkOutput("reset done", 32'(Done), 32'd0);
    checkOutput("reset macEnable", 32'(MacEnable), 32'd0);
    checkOutput("reset rdEn", 32'(RdEn), 32'd0);
    checkOutput("reset result", Result, 32'h0);
    @(posedge Clk); #1;

    applyStimulus("sum123", 10'd3, 10'd0, 10'd0, 10'd1, 10'd1, 32'h40C00000, 6);
    applyStimulus("signFlip", 10'd2, 10'd10, 10'd10, 10'd1, 10'd1, 32'hBF800000, 5);
    @(posedge Clk); #1;
    // Wrap job followed back-to-back by a zero-length job and a single-element job.
    applyStimulus("wrapB", 10'd2, 10'd20, 10'd1022, 10'd3, 10'd4, 32'h40600000, 5);
    applyStimulus("zeroLen", 10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 32'h0, 1);
    applyStimulus("single", 10'd1, 10'd1, 10'd0, 10'd1, 10'd1, 32'h40000000, 4);

    // Abort a length-8 job in the middle of accumulation.
    Start = 1'b1; Length = 10'd8; BaseA = 10'd100; BaseB = 10'd200; StrideA = 10'd1; StrideB = 10'd1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("abort busyBefore", 32'(Busy), 32'd1);
    checkOutput("abort macEnBefore", 32'(MacEnable), 32'd1);
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    checkOutput("abort busyAfter", 32'(Busy), 32'd0);
    checkOutput("abort macEnAfter", 32'(MacEnable), 32'd0);
    checkOutput("abort rdEnAfter", 32'(RdEn), 32'd0);
    doneSeen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk);
      if (Done) doneSeen++;
    end
    checkOutput("abort noDone", 32'(doneSeen), 32'd0);
    checkOutput("abort resultHeld", Result, 32'h40000000);
    @(posedge Clk); #1;
    applyStimulus("afterAbort", 10'd8, 10'd100, 10'd200, 10'd1, 10'd1, 32'h41000000, 11);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
